// File: rtl/snake_head_ctrl.sv
// snake_head_ctrl: snake movement engine.
// Steps the head one cell per move tick, keeps the last MAX_LEN head
// positions for the body renderer, and flags wall/self collisions.
module snake_head_ctrl #(
  parameter int GRID_W   = 64,
  parameter int GRID_H   = 48,
  parameter int START_X  = 10,
  parameter int START_Y  = 10,
  parameter int TICK_DIV = 5_000_000,
  parameter int MAX_LEN  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] dir_req,
  input  logic [3:0] score,
  input  logic [3:0] seg_idx,
  output logic [6:0] head_x,
  output logic [5:0] head_y,
  output logic       move_strobe,
  output logic       game_over,
  output logic [6:0] seg_x,
  output logic [5:0] seg_y,
  output logic       seg_valid
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  // one-hot {up,down,left,right}
  localparam logic [3:0] D_UP    = 4'b1000;
  localparam logic [3:0] D_DOWN  = 4'b0100;
  localparam logic [3:0] D_LEFT  = 4'b0010;
  localparam logic [3:0] D_RIGHT = 4'b0001;

  typedef struct packed {
    logic [6:0] x;
    logic [5:0] y;
  } pos_t;

  localparam pos_t START_POS = {7'(START_X), 6'(START_Y)};

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    dir;
  logic [3:0]    pending;
  pos_t          hist [MAX_LEN];

  logic       run;
  logic       tc;
  logic [4:0] len;
  logic [4:0] score_p1;
  logic       req_onehot;
  logic [3:0] ref_dir;
  logic [3:0] ref_rev;
  logic       accept;
  pos_t       cur;
  pos_t       nxt;
  logic       wall_hit;
  logic       self_hit;
  logic       collide;
  pos_t       seg_pos;

  assign run = (state == S_RUN);
  assign tc  = run && (cnt == CW'(TICK_DIV - 1));

  // live body length, saturated at the history depth
  assign score_p1 = {1'b0, score} + 5'd1;
  assign len      = (score_p1 > 5'(MAX_LEN)) ? 5'(MAX_LEN) : score_p1;

  // At TC the pending direction becomes the committed one, so a same-cycle
  // request is screened against that to avoid a 180-degree turn next step.
  assign req_onehot = (dir_req != 4'd0) && ((dir_req & (dir_req - 4'd1)) == 4'd0);
  assign ref_dir    = tc ? pending : dir;
  assign ref_rev    = {ref_dir[2], ref_dir[3], ref_dir[0], ref_dir[1]};
  assign accept     = run && req_onehot && (dir_req != ref_rev);

  assign cur = hist[0];

  // next head position from the direction being committed, with wall check
  always_comb begin
    nxt      = cur;
    wall_hit = 1'b0;
    case (pending)
      D_UP:    if (cur.y == 6'd0)              wall_hit = 1'b1; else nxt.y = cur.y - 6'd1;
      D_DOWN:  if (cur.y == 6'(GRID_H - 1))    wall_hit = 1'b1; else nxt.y = cur.y + 6'd1;
      D_LEFT:  if (cur.x == 7'd0)              wall_hit = 1'b1; else nxt.x = cur.x - 7'd1;
      D_RIGHT: if (cur.x == 7'(GRID_W - 1))    wall_hit = 1'b1; else nxt.x = cur.x + 7'd1;
      default: wall_hit = 1'b0;
    endcase
  end

  // self collision against the body cells that remain after this step (0..len-2)
  always_comb begin
    self_hit = 1'b0;
    for (int k = 0; k < MAX_LEN - 1; k++) begin
      if ((k + 2 <= int'(len)) && (hist[k] == nxt)) self_hit = 1'b1;
    end
  end

  assign collide = wall_hit | self_hit;

  // game state and move-tick counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state <= S_RUN;
          cnt   <= '0;
        end
        S_RUN: begin
          cnt <= tc ? '0 : cnt + 1'b1;
          if (tc && collide) state <= S_OVER;
        end
        S_OVER: if (start) begin
          state <= S_RUN;
          cnt   <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // direction: latest legal request goes to pending, committed at TC
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir     <= D_RIGHT;
      pending <= D_RIGHT;
    end else if (state == S_OVER && start) begin
      dir     <= D_RIGHT;
      pending <= D_RIGHT;
    end else if (run) begin
      if (tc)     dir     <= pending;
      if (accept) pending <= dir_req;
    end
  end

  // head history shift register; frozen on collision
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_LEN; i++) hist[i] <= START_POS;
    end else if (state == S_OVER && start) begin
      for (int i = 0; i < MAX_LEN; i++) hist[i] <= START_POS;
    end else if (tc && !collide) begin
      for (int i = 1; i < MAX_LEN; i++) hist[i] <= hist[i-1];
      hist[0] <= nxt;
    end
  end

  // one-cycle pulse alongside each new head value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) move_strobe <= 1'b0;
    else        move_strobe <= tc && !collide;
  end

  assign head_x    = cur.x;
  assign head_y    = cur.y;
  assign game_over = (state == S_OVER);

  // segment read port
  assign seg_pos   = (int'(seg_idx) < MAX_LEN) ? hist[seg_idx[IW-1:0]] : hist[0];
  assign seg_x     = seg_pos.x;
  assign seg_y     = seg_pos.y;
  assign seg_valid = ({1'b0, seg_idx} < len);

endmodule
